// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with start timeout and single outstanding split transaction.
// Optional build macro BUS_ARB_ROUND_ROBIN_EN: least-recently-granted priority instead of fixed M1-first.
module bus_arbiter #(
  parameter int START_TMO = 8,
  parameter int CW        = $clog2(START_TMO + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic M1_BREQ,
  input  logic M2_BREQ,
  input  logic B_UTIL,
  input  logic SPL_4K_SEL,
  input  logic SPL_READY,
  output logic M1_BGRANT,
  output logic M2_BGRANT,
  output logic MSEL,
  output logic B_SBSY
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT1 = 2'd1, GNT2 = 2'd2} state_t;

  localparam logic [CW-1:0] TMO_LAST = CW'(START_TMO - 1);

  state_t        state_q, state_d;
  logic          msel_q, msel_d;
  logic          sbsy_q, sbsy_d;
  logic          owner_q, owner_d;   // parked master: 0 = M1, 1 = M2 (valid while sbsy_q)
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;     // B_UTIL observed during this tenure
  logic          lock1_q, lock1_d;   // timed out, waiting for BREQ to drop
  logic          lock2_q, lock2_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic          last_q, last_d;     // most recent grant: 0 = M1, 1 = M2
`endif

  logic parked1, parked2, resume1, resume2, elig1, elig2;
  logic in_gnt, cur_breq, split_hit, tmo_hit;

  assign parked1   = sbsy_q && !owner_q;
  assign parked2   = sbsy_q &&  owner_q;
  assign resume1   = parked1 && M1_BREQ && SPL_READY;
  assign resume2   = parked2 && M2_BREQ && SPL_READY;
  assign elig1     = M1_BREQ && !lock1_q && !parked1;
  assign elig2     = M2_BREQ && !lock2_q && !parked2;
  assign in_gnt    = (state_q == GNT1) || (state_q == GNT2);
  assign cur_breq  = (state_q == GNT1) ? M1_BREQ : M2_BREQ;
  // A second split while one is pending is ignored and the first owner is kept.
  assign split_hit = in_gnt && SPL_4K_SEL && !sbsy_q;
  assign tmo_hit   = in_gnt && !seen_q && !B_UTIL && (cnt_q == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      msel_q  <= 1'b0;
      sbsy_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      lock1_q <= 1'b0;
      lock2_q <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      msel_q  <= msel_d;
      sbsy_q  <= sbsy_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      lock1_q <= lock1_d;
      lock2_q <= lock2_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (resume1)                state_d = GNT1;
        else if (resume2)           state_d = GNT2;
        else if (elig1 && elig2) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
          state_d = last_q ? GNT1 : GNT2;
`else
          state_d = GNT1;
`endif
        end
        else if (elig1)             state_d = GNT1;
        else if (elig2)             state_d = GNT2;
      end
      GNT1, GNT2: begin
        if (split_hit || !cur_breq || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    msel_d  = msel_q;
    sbsy_d  = sbsy_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    lock1_d = lock1_q && M1_BREQ;
    lock2_d = lock2_q && M2_BREQ;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif

    if (state_q == IDLE) begin
      cnt_d  = '0;
      seen_d = 1'b0;
      if (state_d == GNT1) begin
        msel_d = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_d = 1'b0;
`endif
      end else if (state_d == GNT2) begin
        msel_d = 1'b1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_d = 1'b1;
`endif
      end
      if (resume1 || resume2) sbsy_d = 1'b0;
    end else begin
      if (!seen_q && !B_UTIL) cnt_d = cnt_q + 1'b1;
      seen_d = seen_q || B_UTIL;
      if (split_hit) begin
        sbsy_d  = 1'b1;
        owner_d = (state_q == GNT2);
      end else if (tmo_hit) begin
        if (state_q == GNT1 && M1_BREQ) lock1_d = 1'b1;
        if (state_q == GNT2 && M2_BREQ) lock2_d = 1'b1;
      end
    end

    // Parked owner gave up before resumption: abandon the split.
    if ((parked1 && !M1_BREQ) || (parked2 && !M2_BREQ)) sbsy_d = 1'b0;
  end

  assign M1_BGRANT = (state_q == GNT1);
  assign M2_BGRANT = (state_q == GNT2);
  assign MSEL      = msel_q;
  assign B_SBSY    = sbsy_q;

endmodule
